// File: rtl/rf_xfer_engine.sv
// rf_xfer_engine
// Bulk-transfer initiator for the register file. A command selects a direction,
// a base register and a word count.
//   LOAD  streams words in and writes them to consecutive registers.
//   STORE reads consecutive registers and streams them out.
// Register addresses wrap modulo 2**ADDR_W.
//
// Ports
//   clk, rst                               clock, synchronous active-high reset
//   cmd_valid/cmd_ready                    command handshake
//   cmd_dir, cmd_base, cmd_count           command fields (dir 0=LOAD, 1=STORE)
//   in_valid/in_ready/in_data              LOAD word stream
//   out_valid/out_ready/out_data           STORE word stream (registered)
//   rf_we/rf_waddr/rf_wdata                regfile write port (registered)
//   rf_raddr/rf_rdata                      regfile async read port
//   done                                   1-cycle completion pulse
//   err                                    1-cycle pulse for a rejected command
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready high
// S_LOAD  | accepting input words and writing them to the regfile
// S_STORE | reading registers into the output register
// S_FIN   | done pulse, then back to idle
module rf_xfer_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FIN} state_t;

    localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   rem;

    logic cmd_ok;
    logic cmd_acc;
    logic ld_hs;
    logic st_load;
    logic st_drain;

    assign cmd_ok   = (cmd_count != '0) && (cmd_count <= MAX_COUNT);
    assign rf_raddr = addr;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;
        cmd_acc   = 1'b0;
        ld_hs     = 1'b0;
        st_load   = 1'b0;
        st_drain  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                cmd_acc   = cmd_valid;
                if (cmd_valid && cmd_ok)
                    state_nxt = cmd_dir ? S_STORE : S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                ld_hs    = in_valid;
                if (in_valid && (rem == REM_ONE))
                    state_nxt = S_FIN;
            end
            S_STORE: begin
                // Refill the output register whenever it is empty or being
                // drained this cycle, as long as words remain.
                st_load = (!out_valid || out_ready) && (rem != '0);
                if ((rem == '0) && out_valid && out_ready) begin
                    st_drain  = 1'b1;
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            rem       <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            rf_we <= ld_hs;
            err   <= cmd_acc && !cmd_ok;
            if (cmd_acc && cmd_ok) begin
                addr <= cmd_base;
                rem  <= cmd_count;
            end
            if (ld_hs) begin
                rf_waddr <= addr;
                rf_wdata <= in_data;
                addr     <= addr + ADDR_ONE;
                rem      <= rem - REM_ONE;
            end
            if (st_load) begin
                out_data  <= rf_rdata;
                out_valid <= 1'b1;
                addr      <= addr + ADDR_ONE;
                rem       <= rem - REM_ONE;
            end else if (st_drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_xfer_engine.sv
module tb_rf_xfer_engine;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_count;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              done;
    logic              err;

    int n_assert = 0;
    int n_fail   = 0;

    rf_xfer_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Register file fixture: r0 discards writes and reads zero.
    logic [DATA_W-1:0] regs [32] = '{default: '0};
    always @(posedge clk) if (rf_we && rf_waddr != 0) regs[rf_waddr] <= rf_wdata;
    assign rf_rdata = regs[rf_raddr];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic dir, input logic [4:0] base, input logic [5:0] count);
        chk("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_base  = base;
        cmd_count = count;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Back-to-back LOAD of count words dbase, dbase+1, ...
    task automatic do_load(input logic [4:0] base, input int count, input logic [31:0] dbase);
        logic [4:0] a;
        issue(1'b0, base, 6'(count));
        chk("load_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = dbase;
        for (int i = 0; i < count; i++) begin
            tick();
            a = base + 5'(i);
            chk("load_we", rf_we, 1);
            chk("load_waddr", rf_waddr, a);
            chk("load_wdata", rf_wdata, dbase + i);
            chk("load_done", done, (i == count - 1));
            in_data = dbase + i + 1;
        end
        in_valid = 1'b0;
        tick();
        chk("load_after_cmd_ready", cmd_ready, 1);
        chk("load_after_we", rf_we, 0);
        chk("load_after_done", done, 0);
    endtask

    logic [31:0] st_exp [5];
    logic        st_rdy [5];
    logic        gap_v  [6];
    int          nw;
    int          got;
    logic        seen_done;

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_dir = 0; cmd_base = 0; cmd_count = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_rf_raddr", rf_raddr, 0);

        // LOAD base 3, count 4, back-to-back
        do_load(5'd3, 4, 32'hA0A0_0000);
        chk("reg3", regs[3], 32'hA0A0_0000);
        chk("reg6", regs[6], 32'hA0A0_0003);

        // Preset r30,r31,r0(discarded),r1 via a wrapping LOAD
        do_load(5'd30, 4, 32'hC000_0030);
        chk("reg0_discarded", regs[0], 0);

        // STORE base 30 count 4, out_ready held high
        out_ready = 1'b1;
        st_exp[0] = 32'hC000_0030; st_exp[1] = 32'hC000_0031;
        st_exp[2] = 32'h0;         st_exp[3] = 32'hC000_0033;
        issue(1'b1, 5'd30, 6'd4);
        chk("st_first_not_yet_valid", out_valid, 0);
        chk("st_cmd_ready_busy", cmd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_valid", out_valid, 1);
            chk("st_data", out_data, st_exp[i]);
            chk("st_done_early", done, 0);
        end
        tick();
        chk("st_end_valid", out_valid, 0);
        chk("st_done", done, 1);
        tick();
        chk("st_cmd_ready_after", cmd_ready, 1);
        chk("st_done_one_cycle", done, 0);

        // STORE base 3 count 3 with out_ready 1,0,0,1,1 once data is valid
        out_ready = 1'b0;
        st_exp[0] = 32'hA0A0_0000; st_exp[1] = 32'hA0A0_0001; st_exp[2] = 32'hA0A0_0001;
        st_exp[3] = 32'hA0A0_0001; st_exp[4] = 32'hA0A0_0002;
        st_rdy[0] = 1; st_rdy[1] = 0; st_rdy[2] = 0; st_rdy[3] = 1; st_rdy[4] = 1;
        issue(1'b1, 5'd3, 6'd3);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, st_exp[k]);
            out_ready = st_rdy[k];
            tick();
        end
        chk("stall_end_valid", out_valid, 0);
        chk("stall_done", done, 1);
        out_ready = 1'b0;
        tick();

        // Illegal counts 0 and 33
        issue(1'b1, 5'd4, 6'd0);
        chk("err0_pulse", err, 1);
        chk("err0_cmd_ready", cmd_ready, 1);
        chk("err0_out_valid", out_valid, 0);
        tick();
        chk("err0_one_cycle", err, 0);
        chk("err0_we", rf_we, 0);
        issue(1'b0, 5'd4, 6'd33);
        chk("err33_pulse", err, 1);
        chk("err33_in_ready", in_ready, 0);
        tick();
        chk("err33_one_cycle", err, 0);
        chk("err33_we", rf_we, 0);
        chk("err33_out_valid", out_valid, 0);

        // Count 32 is the largest legal count
        out_ready = 1'b1;
        issue(1'b1, 5'd0, 6'd32);
        chk("cnt32_no_err", err, 0);
        chk("cnt32_busy", cmd_ready, 0);
        got = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tick();
            if (out_valid) got++;
            if (done) seen_done = 1'b1;
        end
        chk("cnt32_done_seen", seen_done, 1);
        chk("cnt32_words", got, 32);
        out_ready = 1'b0;
        tick();

        // LOAD base 10 count 8, reset after the 3rd word
        issue(1'b0, 5'd10, 6'd8);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hD000_0000 + i;
            tick();
        end
        chk("rstmid_we_before", rf_we, 1);
        chk("rstmid_waddr_before", rf_waddr, 12);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rstmid_cmd_ready", cmd_ready, 1);
        chk("rstmid_in_ready", in_ready, 0);
        chk("rstmid_we", rf_we, 0);
        chk("rstmid_waddr", rf_waddr, 0);
        chk("rstmid_wdata", rf_wdata, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_out_valid", out_valid, 0);
        rst = 1'b0;
        chk("rstmid_reg10", regs[10], 32'hD000_0000);
        chk("rstmid_reg12", regs[12], 32'hD000_0002);
        chk("rstmid_reg13", regs[13], 0);

        // LOAD base 20 count 4 with in_valid gaps 1,0,1,1,0,1
        gap_v[0] = 1; gap_v[1] = 0; gap_v[2] = 1; gap_v[3] = 1; gap_v[4] = 0; gap_v[5] = 1;
        issue(1'b0, 5'd20, 6'd4);
        nw = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = gap_v[k];
            in_data  = 32'hE000_0000 + nw;
            tick();
            chk("gap_we", rf_we, gap_v[k]);
            if (gap_v[k]) begin
                chk("gap_waddr", rf_waddr, 20 + nw);
                chk("gap_wdata", rf_wdata, 32'hE000_0000 + nw);
                nw++;
            end
            chk("gap_done", done, (k == 5));
        end
        in_valid = 1'b0;
        tick();
        chk("gap_cmd_ready", cmd_ready, 1);
        chk("gap_we_after", rf_we, 0);
        chk("gap_reg23", regs[23], 32'hE000_0003);
        chk("gap_reg24", regs[24], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
